// File: rtl/pwm_burst_gen.sv
// pwm_burst_gen: turns a free-running counter into a burst of PWM periods with boundary-synchronised duty updates
module pwm_burst_gen #(
    parameter int CNT_W   = 4,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cnt_in,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W:0]     cfg_duty,
    input  logic               start,
    input  logic [BURST_W-1:0] bursts,
    input  logic               abort,
    output logic               pwm_out,
    output logic               period_end,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_W:0]       active_duty_q, active_duty_d;
    logic [CNT_W:0]       pend_duty_q, pend_duty_d;
    logic                 pend_flag_q, pend_flag_d;
    logic [BURST_W-1:0]   remaining_q, remaining_d;
    logic                 pwm_q, pwm_d;
    logic                 period_end_q, period_end_d;
    logic                 boundary, xfer, in_burst, last, apply;
    assign boundary   = cnt_in == {CNT_W{1'b1}};
    assign in_burst   = state_q == ARM || state_q == RUN;
    assign xfer       = cfg_valid & cfg_ready;
    assign last       = remaining_q == BURST_W'(1);
    // A pending duty is applied at the boundary that keeps the burst running, never on the final one.
    assign apply      = ~abort & boundary & pend_flag_q & (state_q == ARM || (state_q == RUN && !last));
    assign cfg_ready  = ~pend_flag_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;
    // Next-state, burst counting and duty bookkeeping
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        period_end_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d     = (bursts == '0) ? DONE : ARM;
                remaining_d = bursts;
            end
            ARM:  state_d = abort ? IDLE : boundary ? RUN : ARM;
            RUN:  if (abort) state_d = IDLE;
                  else if (boundary) begin
                      period_end_d = 1'b1;
                      remaining_d  = remaining_q - BURST_W'(1);
                      state_d      = last ? DONE : RUN;
                  end
            default: state_d = IDLE;
        endcase
        active_duty_d = apply ? pend_duty_q : (xfer & ~in_burst) ? cfg_duty : active_duty_q;
        pend_duty_d   = (xfer & in_burst) ? cfg_duty : pend_duty_q;
        pend_flag_d   = (abort & busy) ? 1'b0 : (xfer & in_burst) ? 1'b1 : apply ? 1'b0 : pend_flag_q;
        pwm_d         = (state_q == RUN) & ~abort & ({1'b0, cnt_in} < active_duty_q);
    end
    // State and output registers, cleared asynchronously so the drive pin drops at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            active_duty_q <= '0;
            pend_duty_q   <= '0;
            pend_flag_q   <= 1'b0;
            remaining_q   <= '0;
            pwm_q         <= 1'b0;
            period_end_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_duty_q <= active_duty_d;
            pend_duty_q   <= pend_duty_d;
            pend_flag_q   <= pend_flag_d;
            remaining_q   <= remaining_d;
            pwm_q         <= pwm_d;
            period_end_q  <= period_end_d;
        end
    end
endmodule
